// File: rtl/if_fetch_queue.sv
// Fetch stage: in-order PC generator issuing to imem plus a DEPTH-entry {pc,inst} queue
// toward decode. Redirect reloads the PC, flushes the queue and drops in-flight responses.
module if_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h1C000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       inst_req_valid,
  input  logic                       inst_req_ready,
  output logic [ADDR_W-1:0]          inst_req_addr,
  input  logic                       inst_resp_valid,
  input  logic [INST_W-1:0]          inst_resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W+INST_W-1:0]   out_bus,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                ENT_W = ADDR_W + INST_W;
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(INST_W / 8);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] resp_pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic [CNT_W-1:0]  count_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [ENT_W-1:0]  mem_q [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           resp_drop;
  logic           push;
  logic           pop;

  // Queued entries plus in-flight requests never exceed DEPTH, so a push always has room.
  assign credit_used    = {1'b0, count_q} + {1'b0, outstanding_q};
  assign inst_req_valid = reset && !redirect_valid && (credit_used < (CNT_W+1)'(DEPTH));
  assign inst_req_addr  = pc_q;
  assign req_fire       = inst_req_valid && inst_req_ready;

  assign resp_drop = (drop_cnt_q != '0) || redirect_valid;
  assign push      = inst_resp_valid && !resp_drop;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign out_valid = (count_q != '0);
  assign out_bus   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fq_count  = count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      // Dropped requests keep holding credit until their response returns.
      outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(inst_resp_valid);
      if (redirect_valid) begin
        pc_q       <= redirect_pc;
        resp_pc_q  <= redirect_pc;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        drop_cnt_q <= outstanding_q - CNT_W'(inst_resp_valid);
      end else begin
        if (req_fire)
          pc_q <= pc_q + STEP;
        if (inst_resp_valid && (drop_cnt_q != '0))
          drop_cnt_q <= drop_cnt_q - CNT_W'(1);
        if (push) begin
          resp_pc_q <= resp_pc_q + STEP;
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {resp_pc_q, inst_resp_data};
  end

`ifndef SYNTHESIS
  resp_needs_credit: assert property (@(posedge clk) disable iff (!reset)
    inst_resp_valid |-> (outstanding_q != '0));
`endif

endmodule
